debounce_edge: RTL and testbench

Input-conditioning stage that sits directly upstream of the team's registered single-bit flops. It takes a raw asynchronous level (push-button, switch, external strobe) and brings it into the `clk` domain with a 2-flop synchronizer. A counter-based state machine then qualifies the level as stable for a programmable number of cycles. The block outputs a clean registered level plus single-cycle rise/fall pulses, suitable for driving the `d` input or an enable of downstream registers.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/sync_2ff.sv | 21 ++
 rtl/debounce_edge.sv | 108 ++++++++++
 tb/tb_debounce_edge.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the input-conditioning (debounce) blocks.
// State encoding and default qualification parameters.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  localparam int unsigned DEF_STABLE_CNT = 50000;
  localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; brings an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronizes din, qualifies a new level for STABLE_CNT cycles, then
// emits a registered level plus single-cycle rise/fall pulses.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CNT - 1);

  logic             s2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s2)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s2) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!s2) begin
          state_d = ST_LOW;
        end else if (cnt_q == CntMax) begin
          state_d = ST_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s2) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (s2) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CntMax) begin
          state_d = ST_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        level_d = 1'b0;
      end
    endcase
    // busy tracks the state register exactly, so derive it from the next state
    busy_d = (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: directed per-cycle vectors, expected outputs
// {level,rise,fall,busy} queued by the stimulus and checked by a separate monitor.
module tb_debounce_edge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut4: STABLE_CNT=4, dut1: STABLE_CNT=1
  logic din4 = 1'b0, rst4 = 1'b1;
  logic din1 = 1'b0, rst1 = 1'b1;
  logic level4, rise4, fall4, busy4;
  logic level1, rise1, fall1, busy1;

  debounce_edge #(.STABLE_CNT(4), .CNT_W(3)) dut4 (
    .clk   (clk),
    .rst   (rst4),
    .din   (din4),
    .level (level4),
    .rise  (rise4),
    .fall  (fall4),
    .busy  (busy4)
  );

  debounce_edge #(.STABLE_CNT(1), .CNT_W(3)) dut1 (
    .clk   (clk),
    .rst   (rst1),
    .din   (din1),
    .level (level1),
    .rise  (rise1),
    .fall  (fall1),
    .busy  (busy1)
  );

  typedef struct {
    bit          sel1;
    logic [3:0]  exp;
    string       name;
    int unsigned idx;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          sel1     = 1'b0;
  string       scen     = "init";
  int unsigned step_idx = 0;

  // One cycle: drive inputs at negedge, queue outputs expected after the next posedge.
  task automatic cyc(input logic d, input logic r, input logic [3:0] e);
    exp_t x;
    @(negedge clk);
    if (sel1) begin
      din1 = d;
      rst1 = r;
    end else begin
      din4 = d;
      rst4 = r;
    end
    x.sel1 = sel1;
    x.exp  = e;
    x.name = scen;
    x.idx  = step_idx;
    sb.push_back(x);
    step_idx++;
  endtask

  task automatic hold(input logic d, input logic r, input logic [3:0] e, input int n);
    for (int i = 0; i < n; i++) cyc(d, r, e);
  endtask

  task automatic start(input string s);
    scen     = s;
    step_idx = 0;
  endtask

  // Monitor: pops one expectation per cycle, compares away from the active edge.
  initial begin
    exp_t       x;
    logic [3:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        act = x.sel1 ? {level1, rise1, fall1, busy1} : {level4, rise4, fall4, busy4};
        n_checks++;
        if (act !== x.exp) begin
          n_errors++;
          $display("FAIL %s step %0d: {level,rise,fall,busy} got %b want %b",
                   x.name, x.idx, act, x.exp);
        end
      end
    end
  end

  initial begin
    // Reset hold with din high; rise 6 edges after first post-reset edge.
    start("reset_hold");
    hold(1, 1, 4'b0000, 3);
    hold(1, 0, 4'b0000, 2);
    hold(1, 0, 4'b0001, 4);
    cyc(1, 0, 4'b1100);
    hold(1, 0, 4'b1000, 2);

    start("clean_fall");
    hold(0, 0, 4'b1000, 2);
    hold(0, 0, 4'b1001, 4);
    cyc(0, 0, 4'b0010);
    hold(0, 0, 4'b0000, 2);

    start("clean_rise");
    hold(1, 0, 4'b0000, 2);
    hold(1, 0, 4'b0001, 4);
    cyc(1, 0, 4'b1100);
    hold(1, 0, 4'b1000, 2);

    start("fall_again");
    hold(0, 0, 4'b1000, 2);
    hold(0, 0, 4'b1001, 4);
    cyc(0, 0, 4'b0010);
    hold(0, 0, 4'b0000, 2);

    // din 1,1,1,0,1,... : the low sample restarts qualification
    start("bounce");
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0001);
    cyc(0, 0, 4'b0001);
    cyc(1, 0, 4'b0001);
    cyc(1, 0, 4'b0000);
    hold(1, 0, 4'b0001, 4);
    cyc(1, 0, 4'b1100);
    hold(1, 0, 4'b1000, 2);

    start("fall_before_rst");
    hold(0, 0, 4'b1000, 2);
    hold(0, 0, 4'b1001, 4);
    cyc(0, 0, 4'b0010);
    hold(0, 0, 4'b0000, 2);

    start("rst_mid_wait");
    hold(1, 0, 4'b0000, 2);
    hold(1, 0, 4'b0001, 2);
    cyc(1, 1, 4'b0000);
    hold(1, 0, 4'b0000, 2);
    hold(1, 0, 4'b0001, 4);
    cyc(1, 0, 4'b1100);
    cyc(1, 0, 4'b1000);

    start("rst_while_high");
    cyc(0, 1, 4'b0000);
    hold(0, 0, 4'b0000, 4);

    // STABLE_CNT=1 instance
    sel1 = 1'b1;
    start("min_reset");
    hold(0, 1, 4'b0000, 2);
    hold(0, 0, 4'b0000, 2);

    start("min_pulse2");
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    cyc(0, 0, 4'b0001);
    cyc(0, 0, 4'b1100);
    cyc(0, 0, 4'b1001);
    cyc(0, 0, 4'b0010);
    hold(0, 0, 4'b0000, 2);

    start("min_pulse1");
    cyc(1, 0, 4'b0000);
    cyc(0, 0, 4'b0000);
    cyc(0, 0, 4'b0001);
    hold(0, 0, 4'b0000, 4);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_errors++;
      $display("FAIL drain: pending expectations got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
